// File: rtl/uart_op_sequencer.sv
// uart_op_sequencer: parses framed operand bytes from the UART receiver,
// drives them into the datapath, waits for the datapath to settle,
// captures the result and returns it byte by byte to the UART transmitter.
module uart_op_sequencer #(
  parameter int         OPERAND_BYTES  = 1,
  parameter int         RESULT_BYTES   = 1,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         SETTLE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 1200000
) (
  input  logic                       iCE_CLK,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  output logic [8*OPERAND_BYTES-1:0] operand,
  output logic                       operand_valid,
  input  logic [8*RESULT_BYTES-1:0]  result,
  output logic                       tx_start,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_busy,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       err_overrun
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    OP_LAST      = 3'(OPERAND_BYTES - 1);
  localparam logic [2:0]    RES_LAST     = 3'(RESULT_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    SEND,
    WAIT_TX
  } state_t;

  state_t                     state;
  logic [8*OPERAND_BYTES-1:0] shadow;
  logic [8*OPERAND_BYTES-1:0] shadow_next;
  logic [8*RESULT_BYTES-1:0]  capture;
  logic [7:0]                 cap_byte;
  logic [2:0]                 op_idx;
  logic [2:0]                 res_idx;
  logic [TW-1:0]              timeout_cnt;
  logic [SW-1:0]              settle_cnt;
  logic                       wait_first;

  // Shadow register with the incoming byte merged at the current index
  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < OPERAND_BYTES; i++) begin
      if (op_idx == 3'(i)) begin
        shadow_next[8*i +: 8] = rx_byte;
      end
    end
  end

  // Capture byte selected by the result index, LSB byte first
  always_comb begin
    cap_byte = '0;
    for (int i = 0; i < RESULT_BYTES; i++) begin
      if (res_idx == 3'(i)) begin
        cap_byte = capture[8*i +: 8];
      end
    end
  end

  // Frame parser, settle/capture sequencing and transmit scheduling
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shadow        <= '0;
      capture       <= '0;
      operand       <= '0;
      operand_valid <= 1'b0;
      tx_start      <= 1'b0;
      tx_byte       <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
      op_idx        <= '0;
      res_idx       <= '0;
      timeout_cnt   <= '0;
      settle_cnt    <= '0;
      wait_first    <= 1'b0;
    end else begin
      operand_valid <= 1'b0;
      tx_start      <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;

      if (rx_valid && (state == SETTLE || state == CAPTURE ||
                       state == SEND || state == WAIT_TX)) begin
        err_overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state       <= LOAD;
            op_idx      <= '0;
            timeout_cnt <= '0;
            shadow      <= '0;
            busy        <= 1'b1;
          end
        end

        LOAD: begin
          if (rx_valid) begin
            timeout_cnt <= '0;
            if (op_idx == OP_LAST) begin
              operand       <= shadow_next;
              operand_valid <= 1'b1;
              settle_cnt    <= '0;
              state         <= SETTLE;
            end else begin
              shadow <= shadow_next;
              op_idx <= op_idx + 3'd1;
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            shadow      <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        CAPTURE: begin
          capture <= result;
          res_idx <= '0;
          state   <= SEND;
        end

        SEND: begin
          if (!tx_busy) begin
            tx_byte    <= cap_byte;
            tx_start   <= 1'b1;
            wait_first <= 1'b1;
            state      <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            if (res_idx == RES_LAST) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              res_idx <= res_idx + 3'd1;
              state   <= SEND;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_op_sequencer.sv
// Directed bench: a one-byte adder instance and a two-byte passthrough
// instance with a manually driven transmitter busy line.
module tb_uart_op_sequencer;

  logic        iCE_CLK;
  logic        rst_n;

  logic        rx_valid_a;
  logic [7:0]  rx_byte_a;
  logic [7:0]  operand_a;
  logic        operand_valid_a;
  logic [7:0]  result_a;
  logic        tx_start_a;
  logic [7:0]  tx_byte_a;
  logic        tx_busy_a;
  logic        busy_a;
  logic        err_timeout_a;
  logic        err_overrun_a;

  logic        rx_valid_b;
  logic [7:0]  rx_byte_b;
  logic [15:0] operand_b;
  logic        operand_valid_b;
  logic [15:0] result_b;
  logic        tx_start_b;
  logic [7:0]  tx_byte_b;
  logic        tx_busy_b;
  logic        busy_b;
  logic        err_timeout_b;
  logic        err_overrun_b;

  int checks;
  int failures;
  int tx_count_a;
  int tx_count_b;
  int valid_count_a;
  int overrun_count_a;
  logic [7:0] last_tx_a;
  int tx_base;

  assign result_a = {4'h0, operand_a[3:0] + operand_a[7:4]};
  assign result_b = operand_b;

  uart_op_sequencer #(
    .OPERAND_BYTES(1), .RESULT_BYTES(1), .SYNC_BYTE(8'hA5),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut_a (
    .iCE_CLK(iCE_CLK), .rst_n(rst_n),
    .rx_valid(rx_valid_a), .rx_byte(rx_byte_a),
    .operand(operand_a), .operand_valid(operand_valid_a),
    .result(result_a),
    .tx_start(tx_start_a), .tx_byte(tx_byte_a), .tx_busy(tx_busy_a),
    .busy(busy_a), .err_timeout(err_timeout_a), .err_overrun(err_overrun_a)
  );

  uart_op_sequencer #(
    .OPERAND_BYTES(2), .RESULT_BYTES(2), .SYNC_BYTE(8'hA5),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut_b (
    .iCE_CLK(iCE_CLK), .rst_n(rst_n),
    .rx_valid(rx_valid_b), .rx_byte(rx_byte_b),
    .operand(operand_b), .operand_valid(operand_valid_b),
    .result(result_b),
    .tx_start(tx_start_b), .tx_byte(tx_byte_b), .tx_busy(tx_busy_b),
    .busy(busy_b), .err_timeout(err_timeout_b), .err_overrun(err_overrun_b)
  );

  // Free-running 100 MHz clock
  initial begin
    iCE_CLK = 1'b0;
    forever #5 iCE_CLK = ~iCE_CLK;
  end

  // Pulse monitors sampled mid-cycle on the falling edge
  always @(negedge iCE_CLK) begin
    if (tx_start_a) begin
      tx_count_a = tx_count_a + 1;
      last_tx_a  = tx_byte_a;
    end
    if (tx_start_b)      tx_count_b      = tx_count_b + 1;
    if (operand_valid_a) valid_count_a   = valid_count_a + 1;
    if (err_overrun_a)   overrun_count_a = overrun_count_a + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCE_CLK);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    rx_valid_a = 1'b1;
    rx_byte_a  = b;
    tick(1);
    rx_valid_a = 1'b0;
    rx_byte_a  = 8'h00;
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_valid_b = 1'b1;
    rx_byte_b  = b;
    tick(1);
    rx_valid_b = 1'b0;
    rx_byte_b  = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      failures = failures + 1;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Directed test sequence
  initial begin
    checks = 0; failures = 0;
    tx_count_a = 0; tx_count_b = 0; valid_count_a = 0; overrun_count_a = 0;
    last_tx_a = 8'h00;
    rst_n = 1'b0;
    rx_valid_a = 1'b0; rx_byte_a = 8'h00; tx_busy_a = 1'b0;
    rx_valid_b = 1'b0; rx_byte_b = 8'h00; tx_busy_b = 1'b1;

    tick(3);
    check("reset_operand", {24'h0, operand_a}, 32'h0);
    check("reset_outputs", {25'h0, operand_valid_a, tx_start_a, busy_a,
                            err_timeout_a, err_overrun_a, busy_b, tx_start_b}, 32'h0);
    check("reset_tx_byte", {24'h0, tx_byte_a}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Basic adder frame: 3 + 5 = 8
    send_a(8'hA5);
    check("load_busy", {31'h0, busy_a}, 32'h1);
    send_a(8'h35);
    check("operand_35", {24'h0, operand_a}, 32'h35);
    check("operand_valid_pulse", {31'h0, operand_valid_a}, 32'h1);
    tick(1);
    check("operand_valid_drop", {31'h0, operand_valid_a}, 32'h0);
    tick(4);
    check("tx_start_not_early", {31'h0, tx_start_a}, 32'h0);
    tick(1);
    check("tx_start_latency", {31'h0, tx_start_a}, 32'h1);
    check("tx_byte_08", {24'h0, tx_byte_a}, 32'h08);
    tick(5);
    check("idle_after_send", {31'h0, busy_a}, 32'h0);
    check("valid_pulses_once", valid_count_a, 1);

    // Wrap-around: F + F drops the carry
    tx_base = tx_count_a;
    send_a(8'hA5);
    send_a(8'hFF);
    tick(10);
    check("tx_byte_wrap", {24'h0, last_tx_a}, 32'h0E);
    send_a(8'hA5);
    send_a(8'h00);
    tick(10);
    check("tx_byte_zero", {24'h0, last_tx_a}, 32'h00);
    check("two_tx_starts", tx_count_a - tx_base, 2);

    // Noise ahead of the header is discarded
    tx_base = tx_count_a;
    send_a(8'h12);
    send_a(8'h34);
    check("noise_stays_idle", {31'h0, busy_a}, 32'h0);
    send_a(8'hA5);
    send_a(8'h21);
    tick(10);
    check("operand_21", {24'h0, operand_a}, 32'h21);
    check("one_tx_start", tx_count_a - tx_base, 1);
    check("tx_byte_03", {24'h0, last_tx_a}, 32'h03);
    check("no_overrun_a", overrun_count_a, 0);

    // Timeout after header with no further bytes
    send_a(8'hA5);
    tick(99);
    check("timeout_not_early", {30'h0, err_timeout_a, busy_a}, 32'h1);
    tick(1);
    check("timeout_pulse", {31'h0, err_timeout_a}, 32'h1);
    check("timeout_busy_low", {31'h0, busy_a}, 32'h0);
    check("timeout_keeps_operand", {24'h0, operand_a}, 32'h21);
    tick(1);
    check("timeout_pulse_drop", {31'h0, err_timeout_a}, 32'h0);
    send_a(8'hA5);
    send_a(8'h11);
    tick(10);
    check("tx_byte_02", {24'h0, last_tx_a}, 32'h02);

    // Two-byte frame with transmitter back-pressure
    send_b(8'hA5);
    send_b(8'h34);
    send_b(8'h12);
    check("operand_1234", {16'h0, operand_b}, 32'h1234);
    tick(50);
    check("backpressure_no_start", tx_count_b, 0);
    tx_busy_b = 1'b0;
    tick(1);
    check("first_start_b", {31'h0, tx_start_b}, 32'h1);
    check("first_byte_34", {24'h0, tx_byte_b}, 32'h34);
    tx_busy_b = 1'b1;
    tick(20);
    check("second_waits_busy", tx_count_b, 1);
    check("tx_byte_held", {24'h0, tx_byte_b}, 32'h34);
    tx_busy_b = 1'b0;
    tick(2);
    check("second_start_b", {31'h0, tx_start_b}, 32'h1);
    check("second_byte_12", {24'h0, tx_byte_b}, 32'h12);

    // Overrun while waiting on the transmitter
    tx_busy_b = 1'b1;
    send_b(8'hA5);
    check("overrun_pulse", {31'h0, err_overrun_b}, 32'h1);
    tick(1);
    check("overrun_pulse_drop", {31'h0, err_overrun_b}, 32'h0);
    tx_busy_b = 1'b0;
    tick(3);
    check("overrun_back_idle", {31'h0, busy_b}, 32'h0);
    send_b(8'h77);
    send_b(8'h55);
    tick(10);
    check("overrun_no_frame", {16'h0, operand_b}, 32'h1234);
    check("tx_count_b_total", tx_count_b, 2);

    // Asynchronous reset in the middle of a frame
    send_b(8'hA5);
    send_b(8'h99);
    check("mid_load_busy", {31'h0, busy_b}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_operand_b", {16'h0, operand_b}, 32'h0);
    check("async_reset_operand_a", {24'h0, operand_a}, 32'h0);
    check("async_reset_flags", {26'h0, busy_b, tx_start_b, operand_valid_b,
                                err_timeout_b, err_overrun_b, busy_a}, 32'h0);
    check("async_reset_tx_byte", {16'h0, tx_byte_b, tx_byte_a}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
